// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the wait-state data memory.
package dmem_pkg;

    localparam int CNT_W = 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << lane;
            SZ_HALF: lane_mask = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: load_extract = {{24{sext & b[7]}}, b};
            SZ_HALF: load_extract = {{16{sext & h[15]}}, h};
            SZ_WORD: load_extract = word;
            default: load_extract = '0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_wait_ctrl_if.sv
// Request/response bundle between the pipeline MEM stage and the data memory.
interface dmem_wait_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ready;
    logic              ack;
    logic              err;

    modport master (output req, we, size, sext, addr, wdata,
                    input  rdata, ready, ack, err);
    modport slave  (input  req, we, size, sext, addr, wdata,
                    output rdata, ready, ack, err);
endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 synchronous RAM with byte write enables and a registered read port.
module dmem_array #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              q,
    input  logic [3:0]               wbe,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [31:0]              wdata
);
    logic [31:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (re) begin
            q <= mem[raddr];
        end
        for (int b = 0; b < 4; b++) begin
            if (wbe[b]) begin
                mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end
endmodule

// File: rtl/dmem_wait_ctrl.sv
// Data memory controller: req/ready/ack handshake with WAIT_CYCLES wait states,
// byte/half/word lane steering, load extension and alignment/range errors.
module dmem_wait_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_wait_ctrl_if.slave bus
);
    // state  | meaning
    // IDLE   | ready, no access in flight
    // WAIT   | counting wait states, req ignored
    // ACCESS | RAM read data valid; store commits and rdata loads on exit
    // RESP   | ack pulse, ready for a back-to-back request

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              acc_err;
    logic              we_q, sext_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_r;
    logic              ram_re;
    logic [IDX_W-1:0]  ram_raddr;
    logic [3:0]        ram_wbe;
    logic [31:0]       ram_q;
    logic [31:0]       wdata_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE, ST_RESP: begin
                if (bus.req) begin
                    accept    = 1'b1;
                    state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT:   if (cnt == '0) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            cnt     <= CNT_LOAD;
            we_q    <= bus.we;
            sext_q  <= bus.sext;
            size_q  <= bus.size;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
        end else if (state == ST_WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign acc_err = (size_q == SZ_ILL)
                   || (size_q == SZ_HALF && addr_q[0])
                   || (size_q == SZ_WORD && addr_q[1:0] != 2'b00)
                   || ((addr_q >> (IDX_W + 2)) != '0);

    // The read is launched on the edge entering ACCESS; with no wait states that
    // is the accept edge itself, so the index comes straight off the bus.
    assign ram_re    = (state_nxt == ST_ACCESS);
    assign ram_raddr = accept ? bus.addr[IDX_W+1:2] : addr_q[IDX_W+1:2];
    assign ram_wbe   = (state == ST_ACCESS && we_q && !acc_err) ? lane_mask(size_q, addr_q[1:0]) : 4'b0000;
    assign wdata_sh  = wdata_q << {addr_q[1:0], 3'b000};

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .re    (ram_re),
        .raddr (ram_raddr),
        .q     (ram_q),
        .wbe   (ram_wbe),
        .waddr (addr_q[IDX_W+1:2]),
        .wdata (wdata_sh)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= '0;
        end else if (state == ST_ACCESS) begin
            if (acc_err) begin
                rdata_r <= '0;
            end else if (!we_q) begin
                rdata_r <= load_extract(ram_q, size_q, addr_q[1:0], sext_q);
            end
        end
    end

    assign bus.ready = (state == ST_IDLE) || (state == ST_RESP);
    assign bus.ack   = (state == ST_RESP);
    assign bus.err   = (state == ST_RESP) && acc_err;
    assign bus.rdata = rdata_r;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Bench for dmem_wait_ctrl: two instances (2 and 0 wait states) checked every cycle
// against a byte-array/latency model, plus directed literal scenarios.
module tb_dmem_wait_ctrl;
    import dmem_pkg::*;

    localparam int DEPTH  = 1024;
    localparam int NBYTES = DEPTH * 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_wait_ctrl_if #(.ADDR_W(32)) bus0 ();
    dmem_wait_ctrl_if #(.ADDR_W(32)) bus1 ();

    dmem_wait_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    dmem_wait_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    logic        req_v [2];
    logic        we_v  [2];
    logic        sext_v[2];
    logic [1:0]  size_v[2];
    logic [31:0] addr_v[2];
    logic [31:0] wdata_v[2];
    logic        rdy_v [2];
    logic        ack_v [2];
    logic        err_v [2];
    logic [31:0] rdata_v[2];

    assign bus0.req = req_v[0];   assign bus1.req = req_v[1];
    assign bus0.we = we_v[0];     assign bus1.we = we_v[1];
    assign bus0.sext = sext_v[0]; assign bus1.sext = sext_v[1];
    assign bus0.size = size_v[0]; assign bus1.size = size_v[1];
    assign bus0.addr = addr_v[0]; assign bus1.addr = addr_v[1];
    assign bus0.wdata = wdata_v[0]; assign bus1.wdata = wdata_v[1];
    assign rdy_v[0] = bus0.ready; assign rdy_v[1] = bus1.ready;
    assign ack_v[0] = bus0.ack;   assign ack_v[1] = bus1.ack;
    assign err_v[0] = bus0.err;   assign err_v[1] = bus1.err;
    assign rdata_v[0] = bus0.rdata; assign rdata_v[1] = bus1.rdata;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: byte-addressed memory, and a countdown to the ack cycle.
    logic [7:0]  bmem [2][NBYTES];
    int          to_ack[2];
    logic        p_we[2], p_sext[2];
    logic [1:0]  p_size[2];
    logic [31:0] p_addr[2], p_wdata[2];
    logic        r_err[2];
    logic [31:0] r_data[2];

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic complete(input int d);
        int nb;
        longint a;
        logic [31:0] v;
        nb = 1 << p_size[d];
        a  = longint'(p_addr[d]);
        v  = '0;
        r_err[d] = (p_size[d] == 2'd3) || (a % nb != 0) || (a >= NBYTES);
        r_data[d] = '0;
        if (!r_err[d]) begin
            if (p_we[d]) begin
                for (int i = 0; i < nb; i++) bmem[d][int'(a) + i] = p_wdata[d][8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) v[8*i +: 8] = bmem[d][int'(a) + i];
                if (p_sext[d] && nb < 4 && v[8*nb-1]) begin
                    for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
                end
                r_data[d] = v;
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            to_ack[d] = -1;
            for (int i = 0; i < NBYTES; i++) bmem[d][i] = 8'h00;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    to_ack[d] = -1;
                end else begin
                    if (to_ack[d] == 1) complete(d);
                    if (to_ack[d] <= 0 && req_v[d]) begin
                        p_we[d] = we_v[d]; p_sext[d] = sext_v[d]; p_size[d] = size_v[d];
                        p_addr[d] = addr_v[d]; p_wdata[d] = wdata_v[d];
                        to_ack[d] = wait_of(d) + 1;
                    end else if (to_ack[d] >= 0) begin
                        to_ack[d]--;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    chk($sformatf("d%0d_rst_ready", d), 32'(rdy_v[d]), 32'd1);
                    chk($sformatf("d%0d_rst_ack", d), 32'(ack_v[d]), 32'd0);
                    chk($sformatf("d%0d_rst_err", d), 32'(err_v[d]), 32'd0);
                    chk($sformatf("d%0d_rst_rdata", d), rdata_v[d], 32'd0);
                end else begin
                    chk($sformatf("d%0d_ready", d), 32'(rdy_v[d]), 32'(to_ack[d] <= 0));
                    chk($sformatf("d%0d_ack", d), 32'(ack_v[d]), 32'(to_ack[d] == 0));
                    if (to_ack[d] == 0) begin
                        chk($sformatf("d%0d_err", d), 32'(err_v[d]), 32'(r_err[d]));
                        if (!p_we[d] || r_err[d])
                            chk($sformatf("d%0d_rdata", d), rdata_v[d], r_data[d]);
                    end
                end
            end
        end
    end

    task automatic wait_ready(input int d);
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy_v[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout d%0d: ready stayed 0 for %0d cycles", d, n);
        end
    endtask

    task automatic op(input int d, input logic w, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd, output logic er);
        @(posedge clk); #1;
        we_v[d] = w; size_v[d] = sz; sext_v[d] = sx; addr_v[d] = a; wdata_v[d] = wd;
        req_v[d] = 1'b1;
        wait_ready(d);
        @(posedge clk); #1;
        req_v[d] = 1'b0;
        lat = 0; rd = '0; er = 1'b0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (ack_v[d]) begin
                rd = rdata_v[d];
                er = err_v[d];
                break;
            end
        end
    endtask

    task automatic rand_fields(input int d);
        we_v[d]   = 1'($urandom_range(1));
        sext_v[d] = 1'($urandom_range(1));
        size_v[d] = ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(2));
        case ($urandom_range(15))
            0:       addr_v[d] = 32'h0000_1000 + $urandom_range(63);
            1:       addr_v[d] = 32'h8000_0000 | $urandom_range(63);
            default: addr_v[d] = $urandom_range(63);
        endcase
        wdata_v[d] = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, n;
        logic [31:0] rd;
        logic        er, acc;
        for (int d = 0; d < 2; d++) begin
            req_v[d] = 1'b0; we_v[d] = 1'b0; sext_v[d] = 1'b0;
            size_v[d] = SZ_BYTE; addr_v[d] = '0; wdata_v[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(rdy_v[0]), 32'd1);
        chk("reset_ack", 32'(ack_v[0]), 32'd0);
        chk("reset_rdata", rdata_v[0], 32'd0);
        chk("reset_err", 32'(err_v[0]), 32'd0);

        op(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, er);
        chk("st_word_latency", 32'(lat), 32'd4);
        chk("st_word_err", 32'(er), 32'd0);
        op(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, rd, er);
        chk("ld_word_latency", 32'(lat), 32'd4);
        chk("ld_word_rdata", rd, 32'hDEAD_BEEF);
        chk("ld_word_err", 32'(er), 32'd0);

        op(0, 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h0000_0080, lat, rd, er);
        op(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, rd, er);
        chk("byte_merge_word", rd, 32'hDEAD_80EF);
        op(0, 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, lat, rd, er);
        chk("ld_byte_sext", rd, 32'hFFFF_FF80);
        op(0, 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, lat, rd, er);
        chk("ld_byte_zext", rd, 32'h0000_0080);

        op(0, 1'b0, SZ_HALF, 1'b0, 32'h13, 32'h0, lat, rd, er);
        chk("misaligned_half_err", 32'(er), 32'd1);
        chk("misaligned_half_rdata", rd, 32'd0);
        chk("misaligned_half_latency", 32'(lat), 32'd4);
        op(0, 1'b0, SZ_WORD, 1'b0, 32'h1000, 32'h0, lat, rd, er);
        chk("range_ld_err", 32'(er), 32'd1);
        chk("range_ld_rdata", rd, 32'd0);
        op(0, 1'b1, SZ_WORD, 1'b0, 32'h1000, 32'h5555_5555, lat, rd, er);
        chk("range_st_err", 32'(er), 32'd1);
        op(0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, lat, rd, er);
        chk("range_st_no_alias", rd, 32'd0);
        op(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, rd, er);
        chk("word_unchanged", rd, 32'hDEAD_80EF);

        // Back-to-back store then load, req held high throughout the store's wait.
        @(posedge clk); #1;
        we_v[0] = 1'b1; size_v[0] = SZ_WORD; sext_v[0] = 1'b0;
        addr_v[0] = 32'h20; wdata_v[0] = 32'h1234_5678; req_v[0] = 1'b1;
        wait_ready(0);
        @(posedge clk); #1;
        we_v[0] = 1'b0; wdata_v[0] = 32'h0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy_v[0] && n < 20);
        chk("b2b_ready_gap", 32'(n), 32'd4);
        chk("b2b_store_ack", 32'(ack_v[0]), 32'd1);
        @(posedge clk); #1;
        req_v[0] = 1'b0;
        lat = 0; rd = '0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (ack_v[0]) begin rd = rdata_v[0]; break; end
        end
        chk("b2b_load_latency", 32'(lat), 32'd4);
        chk("b2b_load_rdata", rd, 32'h1234_5678);

        op(1, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'hCAFE_F00D, lat, rd, er);
        chk("w0_st_latency", 32'(lat), 32'd2);
        op(1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, lat, rd, er);
        chk("w0_ld_latency", 32'(lat), 32'd2);
        chk("w0_ld_rdata", rd, 32'hCAFE_F00D);

        // Reset during the ACCESS cycle of a store must drop it.
        @(posedge clk); #1;
        we_v[1] = 1'b1; size_v[1] = SZ_WORD; addr_v[1] = 32'h40;
        wdata_v[1] = 32'h1111_1111; req_v[1] = 1'b1;
        wait_ready(1);
        @(posedge clk); #1;
        req_v[1] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(rdy_v[1]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acc = 1'b0;
        repeat (4) begin
            @(negedge clk);
            acc = acc | ack_v[1];
        end
        chk("abort_no_ack", 32'(acc), 32'd0);
        op(1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, lat, rd, er);
        chk("abort_word_kept", rd, 32'hCAFE_F00D);

        for (int d = 0; d < 2; d++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 250; i++) begin
                rand_fields(d);
                req_v[d] = 1'b1;
                wait_ready(d);
                @(posedge clk); #1;
                if ($urandom_range(1) == 0) begin
                    req_v[d] = 1'b0;
                    repeat ($urandom_range(4)) @(posedge clk);
                    #1;
                end
            end
            req_v[d] = 1'b0;
            repeat (6) @(posedge clk);
        end

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
